data_io_sync: RTL and testbench
===============================

// Module: data_io_sync
// PURPOSE
//  ARM->FPGA file download receiver, fully synchronous to clk_sys. Oversamples the SS2 SPI link.
//  Packs received bytes into DW-bit words and buffers them in a small FIFO.
//  Delivers words to core memory under clkref_n gating and ioctl_wait back-pressure.
//  Drop-in successor for the download path of the 8-bit SPI-clocked receiver.
// PARAMETERS
//  DW          8       output word width; 8 or 16 only
//  START_ADDR  25'd0   ioctl_addr of first word of every download
//  FIFO_DEPTH  4       word FIFO entries; power of 2, >=2
// PORTS
//  clk_sys         in   1   system clock; must be >=4x SPI_SCK frequency
//  reset_n         in   1   asynchronous active-low reset
//  SPI_SCK         in   1   SPI clock from IO controller (asynchronous)
//  SPI_SS2         in   1   data_io chip select, active low
//  SPI_DI          in   1   SPI data, MSB first
//  clkref_n        in   1   write permitted only in cycles where low
//  ioctl_wait      in   1   core back-pressure; no ioctl_wr while high
//  ioctl_download  out  1   download active
//  ioctl_index     out  8   menu index latched at download start
//  ioctl_wr        out  1   one-cycle strobe; ioctl_dout/ioctl_addr valid
//  ioctl_addr      out  25  word address; advances by DW/8 per word
//  ioctl_dout      out  DW  data word
//  ioctl_fileext   out  24  file extension from FILE_INFO bytes 0x08..0x0A
//  ioctl_filesize  out  32  file size from FILE_INFO bytes 0x1C..0x1F, little-endian
//  ioctl_overflow  out  1   sticky: a word was dropped on full FIFO
// BEHAVIOUR
//  Reset:
//  - All outputs 0; FIFO empty; packer empty.
//  - Receiver ignores SCK until SS2 has been sampled high once after reset.
//  Input sampling:
//  - SCK/SS2/DI pass through 2-FF synchronisers.
//  - A bit is taken in the cycle the synced SCK goes 0->1.
//  - Synced SS2 high clears the bit counter and the FILE_INFO byte counter only.
//  Framing:
//  - Bit count 0..7 forms the command byte.
//  - Then 8..15 repeats, one payload byte per wrap.
//  Commands:
//  - 0x53 payload bit0=1: start download.
//  - 0x53 payload bit0=0: end download.
//  - 0x54: data byte.
//  - 0x55: latch index_reg.
//  - 0x56: FILE_INFO directory entry, byte counter 0..63.
//  - Other commands: ignored.
//  Start:
//  - ioctl_download=1; ioctl_index<=index_reg; address counter<=START_ADDR.
//  - FIFO flushed; packer cleared; ioctl_overflow cleared.
//  - A start while already downloading is a restart with the same effect.
//  Packing:
//  - DW=8: every byte is one word.
//  - DW=16: first byte goes to [7:0], second to [15:8]; the word is pushed on the second byte.
//  - Data bytes arriving while ioctl_download=0 are discarded.
//  End:
//  - A pending half word (odd byte count) is pushed with [15:8]=0.
//  - ioctl_download falls in the first cycle where the end is seen AND the FIFO is empty AND no ioctl_wr is issuing.
//  FIFO:
//  - Push and pop in the same cycle are both honoured; the count is unchanged.
//  - Push when full: the word is dropped and ioctl_overflow is set.
//  Output:
//  - A pop occurs when FIFO non-empty & ~clkref_n & ~ioctl_wait & ioctl_wr was 0 last cycle.
//  - Next cycle: ioctl_wr=1 with the word and the current address; the address counter then adds DW/8.
//  - Address wraps modulo 2^25 silently.
//  - ioctl_dout/ioctl_addr hold their value between strobes.
//  Latency:
//  - Last SCK edge of a word, detected in cycle N, pushes the word in cycle N+1.
//  - With FIFO empty, clkref_n=0 and ioctl_wait=0, ioctl_wr is high in cycle N+3.
//  FILE_INFO: fields update as each byte completes; they are not cleared by a download start.
// TESTING
//  - DW=8: 0x55 0x05, 0x53 0x01, 0x54 AA BB CC, 0x53 0x00 -> index=0x05; writes AA@0, BB@1, CC@2; download falls after the last write.
//  - DW=16: 0x54 11 22 33, then end -> 0x2211@0, 0x0033@2; download falls after the second write.
//  - ioctl_wait held high across 6 bytes, FIFO_DEPTH=4, DW=8 -> 4 words kept; overflow=1; after release exactly 4 writes @0..3.
//  - clkref_n toggling every cycle -> every ioctl_wr falls only in cycles following a clkref_n-low cycle; no two consecutive strobes.
//  - 0x56 with 32 bytes 0..0x1F -> fileext=0x08090A; filesize=0x1F1E1D1C.
//  - reset_n pulsed low mid-byte -> all outputs 0; SCK ignored until SS2 high; the next framed download starts at START_ADDR.

Source files
------------

// File: rtl/data_io_sync.sv
// SPI (SS2) download receiver oversampled on clk_sys: packs bytes into DW-bit words,
// buffers them in a small FIFO and issues ioctl_wr strobes under clkref_n / ioctl_wait.
module data_io_sync #(
  parameter int unsigned DW         = 8,
  parameter logic [24:0] START_ADDR = 25'd0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          SPI_SCK,
  input  logic          SPI_SS2,
  input  logic          SPI_DI,
  input  logic          clkref_n,
  input  logic          ioctl_wait,
  output logic          ioctl_download,
  output logic [7:0]    ioctl_index,
  output logic          ioctl_wr,
  output logic [24:0]   ioctl_addr,
  output logic [DW-1:0] ioctl_dout,
  output logic [23:0]   ioctl_fileext,
  output logic [31:0]   ioctl_filesize,
  output logic          ioctl_overflow
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned STEP_I  = DW / 8;
  localparam logic [24:0] ADDR_STEP = STEP_I[24:0];
  localparam logic [AW:0] FULL_CNT  = FIFO_DEPTH[AW:0];

  typedef enum logic [7:0] {
    CMD_DL    = 8'h53,
    CMD_DATA  = 8'h54,
    CMD_INDEX = 8'h55,
    CMD_INFO  = 8'h56
  } cmd_e;

  logic [1:0]    sck_s, ss_s, di_s;
  logic          sck_d, ss_seen;
  logic          sck_rise, rx_active;
  logic [3:0]    bit_cnt;
  logic [6:0]    sr;
  logic [7:0]    cmd, rx_byte;
  logic          byte_stb;
  logic [5:0]    fi_cnt;
  logic [7:0]    index_reg;
  logic          end_pending;
  logic [24:0]   addr_cnt;

  logic          is_dl, start, end_stb, data_stb, end_seen;
  logic          data_push, pad_push, push_any, do_push, pop, fifo_full;
  logic [DW-1:0] push_word;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sck_s   <= '0;
      ss_s    <= '0;
      di_s    <= '0;
      sck_d   <= 1'b0;
      ss_seen <= 1'b0;
    end else begin
      sck_s   <= {sck_s[0], SPI_SCK};
      ss_s    <= {ss_s[0], SPI_SS2};
      di_s    <= {di_s[0], SPI_DI};
      sck_d   <= sck_s[1];
      ss_seen <= ss_seen | ss_s[1];
    end
  end

  // Nothing is framed until SS2 has been seen deasserted since reset.
  assign sck_rise  = sck_s[1] & ~sck_d;
  assign rx_active = ss_seen & ~ss_s[1];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      sr       <= '0;
      cmd      <= '0;
      rx_byte  <= '0;
      byte_stb <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      if (ss_s[1]) begin
        bit_cnt <= '0;
      end else if (rx_active && sck_rise) begin
        sr <= {sr[5:0], di_s[1]};
        if (bit_cnt == 4'd7) cmd <= {sr, di_s[1]};
        if (bit_cnt == 4'd15) begin
          rx_byte  <= {sr, di_s[1]};
          byte_stb <= 1'b1;
          bit_cnt  <= 4'd8;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

  assign is_dl    = byte_stb && (cmd == CMD_DL);
  assign start    = is_dl && rx_byte[0];
  assign end_stb  = is_dl && !rx_byte[0] && ioctl_download;
  assign data_stb = byte_stb && (cmd == CMD_DATA) && ioctl_download;
  assign end_seen = end_pending | end_stb;

  if (DW == 16) begin : g_pack16
    logic [7:0] lo;
    logic       half;
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        lo   <= '0;
        half <= 1'b0;
      end else if (start || end_stb) begin
        half <= 1'b0;
      end else if (data_stb) begin
        if (!half) lo <= rx_byte;
        half <= ~half;
      end
    end
    assign data_push = data_stb & half;
    assign pad_push  = end_stb & half;
    assign push_word = pad_push ? {8'h00, lo} : {rx_byte, lo};
  end else begin : g_pack8
    assign data_push = data_stb;
    assign pad_push  = 1'b0;
    assign push_word = rx_byte;
  end

  assign push_any  = data_push | pad_push;
  assign fifo_full = (fifo_cnt == FULL_CNT);
  assign pop       = (fifo_cnt != '0) && !clkref_n && !ioctl_wait && !ioctl_wr && !start;
  assign do_push   = push_any && (!fifo_full || pop);

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !do_push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // Download ends only once the FIFO has drained and the last strobe has retired.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ioctl_wr       <= 1'b0;
      ioctl_dout     <= '0;
      ioctl_addr     <= '0;
      addr_cnt       <= '0;
      ioctl_download <= 1'b0;
      ioctl_index    <= '0;
      ioctl_overflow <= 1'b0;
      end_pending    <= 1'b0;
      index_reg      <= '0;
    end else begin
      ioctl_wr <= pop;
      if (pop) begin
        ioctl_dout <= mem[rd_ptr];
        ioctl_addr <= addr_cnt;
        addr_cnt   <= addr_cnt + ADDR_STEP;
      end
      if (start) begin
        ioctl_download <= 1'b1;
        ioctl_index    <= index_reg;
        addr_cnt       <= START_ADDR;
        ioctl_overflow <= 1'b0;
        end_pending    <= 1'b0;
      end else begin
        if (push_any && fifo_full && !pop) ioctl_overflow <= 1'b1;
        if (end_seen && (fifo_cnt == '0) && !push_any && !ioctl_wr) begin
          ioctl_download <= 1'b0;
          end_pending    <= 1'b0;
        end else if (end_stb) begin
          end_pending <= 1'b1;
        end
      end
      if (byte_stb && (cmd == CMD_INDEX)) index_reg <= rx_byte;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      fi_cnt         <= '0;
      ioctl_fileext  <= '0;
      ioctl_filesize <= '0;
    end else if (ss_s[1]) begin
      fi_cnt <= '0;
    end else if (byte_stb && (cmd == CMD_INFO)) begin
      fi_cnt <= fi_cnt + 6'd1;
      case (fi_cnt)
        6'h08: ioctl_fileext[23:16]  <= rx_byte;
        6'h09: ioctl_fileext[15:8]   <= rx_byte;
        6'h0A: ioctl_fileext[7:0]    <= rx_byte;
        6'h1C: ioctl_filesize[7:0]   <= rx_byte;
        6'h1D: ioctl_filesize[15:8]  <= rx_byte;
        6'h1E: ioctl_filesize[23:16] <= rx_byte;
        6'h1F: ioctl_filesize[31:24] <= rx_byte;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_io_sync.sv
// Bench for data_io_sync: one DW=8 and one DW=16 instance on a shared SPI bus,
// expected writes queued as bytes are sent and matched against each ioctl_wr strobe.
module tb_data_io_sync;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        sck, ss_a, ss_b, di, clkref_n, wait_r;
  logic        clk_tog;

  logic        a_dl, a_wr, a_ovf;
  logic [7:0]  a_index;
  logic [24:0] a_addr;
  logic [7:0]  a_dout;
  logic [23:0] a_ext;
  logic [31:0] a_size;

  logic        b_dl, b_wr, b_ovf;
  logic [7:0]  b_index;
  logic [24:0] b_addr;
  logic [15:0] b_dout;
  logic [23:0] b_ext;
  logic [31:0] b_size;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [40:0] qa[$];
  logic [40:0] qb[$];
  logic [7:0]  fb[$];

  always #5 clk_sys = ~clk_sys;

  data_io_sync #(.DW(8), .START_ADDR(25'd0), .FIFO_DEPTH(4)) u_dut8 (
    .clk_sys(clk_sys), .reset_n(reset_n), .SPI_SCK(sck), .SPI_SS2(ss_a), .SPI_DI(di),
    .clkref_n(clkref_n), .ioctl_wait(wait_r), .ioctl_download(a_dl), .ioctl_index(a_index),
    .ioctl_wr(a_wr), .ioctl_addr(a_addr), .ioctl_dout(a_dout), .ioctl_fileext(a_ext),
    .ioctl_filesize(a_size), .ioctl_overflow(a_ovf)
  );

  data_io_sync #(.DW(16), .START_ADDR(25'd0), .FIFO_DEPTH(4)) u_dut16 (
    .clk_sys(clk_sys), .reset_n(reset_n), .SPI_SCK(sck), .SPI_SS2(ss_b), .SPI_DI(di),
    .clkref_n(clkref_n), .ioctl_wait(wait_r), .ioctl_download(b_dl), .ioctl_index(b_index),
    .ioctl_wr(b_wr), .ioctl_addr(b_addr), .ioctl_dout(b_dout), .ioctl_fileext(b_ext),
    .ioctl_filesize(b_size), .ioctl_overflow(b_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bit(input logic v);
    sck = 1'b0;
    di  = v;
    cyc(4);
    sck = 1'b1;
    cyc(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic ss_set(input int sel, input logic v);
    if (sel == 0) ss_a = v;
    else          ss_b = v;
  endtask

  task automatic frame(input int sel, input logic [7:0] c);
    ss_set(sel, 1'b0);
    cyc(4);
    send_byte(c);
    foreach (fb[i]) send_byte(fb[i]);
    sck = 1'b0;
    cyc(4);
    ss_set(sel, 1'b1);
    cyc(8);
    fb.delete();
  endtask

  task automatic wait_idle(input int sel);
    int n;
    n = 0;
    while (n < 4000 && ((sel == 0) ? (qa.size() != 0 || a_dl) : (qb.size() != 0 || b_dl))) begin
      cyc(1);
      n++;
    end
    chk((sel == 0) ? "a_drain" : "b_drain", 32'(n < 4000), 32'd1);
  endtask

  // clkref_n is either held low or toggled every cycle.
  initial begin
    clkref_n = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      clkref_n = clk_tog ? ~clkref_n : 1'b0;
    end
  end

  logic a_wr_p = 1'b0, b_wr_p = 1'b0, a_dl_p = 1'b0, b_dl_p = 1'b0;
  logic clk_p = 1'b1, wait_p = 1'b1;
  logic [40:0] e;

  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (a_wr) begin
        chk("a_no_b2b", 32'(a_wr_p), 32'd0);
        chk("a_clkref_gate", 32'(clk_p), 32'd0);
        chk("a_wait_gate", 32'(wait_p), 32'd0);
        if (qa.size() == 0) chk("a_unexpected_wr", 32'd1, 32'd0);
        else begin
          e = qa.pop_front();
          chk("a_addr", 32'(a_addr), 32'(e[40:16]));
          chk("a_dout", 32'(a_dout), 32'(e[15:0]));
        end
      end
      if (b_wr) begin
        chk("b_no_b2b", 32'(b_wr_p), 32'd0);
        chk("b_clkref_gate", 32'(clk_p), 32'd0);
        if (qb.size() == 0) chk("b_unexpected_wr", 32'd1, 32'd0);
        else begin
          e = qb.pop_front();
          chk("b_addr", 32'(b_addr), 32'(e[40:16]));
          chk("b_dout", 32'(b_dout), 32'(e[15:0]));
        end
      end
      if (a_dl_p && !a_dl) chk("a_dl_fall_pending", 32'(qa.size()), 32'd0);
      if (b_dl_p && !b_dl) chk("b_dl_fall_pending", 32'(qb.size()), 32'd0);
    end
    a_wr_p = a_wr;
    b_wr_p = b_wr;
    a_dl_p = a_dl;
    b_dl_p = b_dl;
    clk_p  = clkref_n;
    wait_p = wait_r;
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    sck = 1'b0; di = 1'b0; ss_a = 1'b1; ss_b = 1'b1;
    wait_r = 1'b0; clk_tog = 1'b0;
    cyc(5);
    chk("rst_a_dl", 32'(a_dl), 32'd0);
    chk("rst_a_wr", 32'(a_wr), 32'd0);
    chk("rst_a_addr", 32'(a_addr), 32'd0);
    chk("rst_a_index", 32'(a_index), 32'd0);
    chk("rst_b_dout", 32'(b_dout), 32'd0);
    chk("rst_b_ovf", 32'(b_ovf), 32'd0);
    reset_n = 1'b1;
    cyc(10);

    // DW=8 basic download
    fb = '{8'h05};             frame(0, 8'h55);
    fb = '{8'h01};             frame(0, 8'h53);
    chk("a_dl_start", 32'(a_dl), 32'd1);
    qa.push_back({25'd0, 16'h00AA});
    qa.push_back({25'd1, 16'h00BB});
    qa.push_back({25'd2, 16'h00CC});
    fb = '{8'hAA, 8'hBB, 8'hCC}; frame(0, 8'h54);
    fb = '{8'h00};             frame(0, 8'h53);
    wait_idle(0);
    chk("a_index", 32'(a_index), 32'h05);
    chk("a_dl_end", 32'(a_dl), 32'd0);

    // DW=16 packing with odd byte count
    fb = '{8'h01};             frame(1, 8'h53);
    qb.push_back({25'd0, 16'h2211});
    qb.push_back({25'd2, 16'h0033});
    fb = '{8'h11, 8'h22, 8'h33}; frame(1, 8'h54);
    fb = '{8'h00};             frame(1, 8'h53);
    wait_idle(1);
    chk("b_dl_end", 32'(b_dl), 32'd0);

    // overflow under held ioctl_wait
    wait_r = 1'b1;
    fb = '{8'h01};             frame(0, 8'h53);
    for (int i = 0; i < 4; i++) qa.push_back({25'(i), 16'(8'h10 + i)});
    fb = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15}; frame(0, 8'h54);
    cyc(10);
    chk("a_ovf_set", 32'(a_ovf), 32'd1);
    chk("a_dl_held", 32'(a_dl), 32'd1);
    chk("a_wait_q", 32'(qa.size()), 32'd4);
    wait_r = 1'b0;
    cyc(40);
    fb = '{8'h00};             frame(0, 8'h53);
    wait_idle(0);

    // clkref_n toggling with a full FIFO released at once
    clk_tog = 1'b1;
    wait_r = 1'b1;
    fb = '{8'h01};             frame(0, 8'h53);
    chk("a_ovf_clr", 32'(a_ovf), 32'd0);
    for (int i = 0; i < 4; i++) qa.push_back({25'(i), 16'(8'h20 + i)});
    fb = '{8'h20, 8'h21, 8'h22, 8'h23}; frame(0, 8'h54);
    wait_r = 1'b0;
    cyc(40);
    fb = '{8'h00};             frame(0, 8'h53);
    wait_idle(0);
    chk("a_ovf_none", 32'(a_ovf), 32'd0);
    clk_tog = 1'b0;
    cyc(4);

    // FILE_INFO directory entry
    for (int i = 0; i < 32; i++) fb.push_back(8'(i));
    frame(0, 8'h56);
    chk("a_fileext", 32'(a_ext), 32'h0008090A);
    chk("a_filesize", a_size, 32'h1F1E1D1C);
    fb = '{8'h01};             frame(0, 8'h53);
    chk("a_fileext_kept", 32'(a_ext), 32'h0008090A);
    fb = '{8'h00};             frame(0, 8'h53);
    wait_idle(0);

    // reset mid-byte during an active download
    fb = '{8'h01};             frame(0, 8'h53);
    qa.push_back({25'd0, 16'h0044});
    ss_a = 1'b0;
    cyc(4);
    send_byte(8'h54);
    send_byte(8'h44);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    cyc(20);
    chk("a_pre_rst_q", 32'(qa.size()), 32'd0);
    #3 reset_n = 1'b0;
    cyc(3);
    chk("rst2_a_dl", 32'(a_dl), 32'd0);
    chk("rst2_a_addr", 32'(a_addr), 32'd0);
    chk("rst2_a_dout", 32'(a_dout), 32'd0);
    chk("rst2_a_ext", 32'(a_ext), 32'd0);
    chk("rst2_a_size", a_size, 32'd0);
    reset_n = 1'b1;
    cyc(4);
    send_byte(8'h53);
    send_byte(8'h01);
    sck = 1'b0;
    cyc(10);
    chk("a_sck_ignored", 32'(a_dl), 32'd0);
    ss_a = 1'b1;
    cyc(8);
    fb = '{8'h01};             frame(0, 8'h53);
    qa.push_back({25'd0, 16'h0077});
    fb = '{8'h77};             frame(0, 8'h54);
    fb = '{8'h00};             frame(0, 8'h53);
    wait_idle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
